// File: rtl/lif_pkg.sv
// Shared helpers for the LIF network: saturating add, shift leak and
// clog2-based width helpers used by the neuron and the top level.
package lif_pkg;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(input int n, input int w_wt);
    return w_wt + $clog2(n + 1);
  endfunction

  // a + b clamped to 2^w - 1; callers cast the result down to w bits
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

  function automatic logic [31:0] leak(input logic [31:0] s, input int sh);
    return s - (s >> sh);
  endfunction

endpackage

// File: rtl/lif_neuron_p.sv
// Single leaky integrate-and-fire neuron with saturating membrane,
// runtime threshold and a refractory counter; frozen while en is low.
module lif_neuron_p
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] thresh,
  output logic         spike,
  output logic         fire,
  output logic [W-1:0] state
);

  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT);

  logic [W-1:0]  state_reg, state_next;
  logic          spike_reg, spike_next;
  logic [RW-1:0] refr_reg, refr_next;
  logic [W-1:0]  nxt;

  always_comb begin
    state_next = state_reg;
    spike_next = spike_reg;
    refr_next  = refr_reg;
    fire       = 1'b0;
    nxt        = W'(sat_add(leak(32'(state_reg), LEAK_SHIFT), 32'(cur), W));
    if (en) begin
      if (refr_reg != '0) begin
        refr_next  = refr_reg - RW'(1);
        state_next = '0;
        spike_next = 1'b0;
      end else if (nxt >= thresh) begin
        fire       = 1'b1;
        spike_next = 1'b1;
        state_next = '0;
        refr_next  = REFR_LOAD;
      end else begin
        spike_next = 1'b0;
        state_next = nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      spike_reg <= 1'b0;
      refr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      spike_reg <= spike_next;
      refr_reg  <= refr_next;
    end
  end

  assign spike = spike_reg;
  assign state = state_reg;

endmodule

// File: rtl/lif_layer_net.sv
// Two-layer LIF network: N_IN hidden neurons, weighted spike sum register,
// one output neuron and a saturating output-spike counter.
module lif_layer_net
  import lif_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int W          = 8,
  parameter int W_WT       = 4,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_IN*W-1:0]       current,
  input  logic                    wt_we,
  input  logic [addr_w(N_IN)-1:0] wt_addr,
  input  logic [W_WT-1:0]         wt_data,
  input  logic [W-1:0]            hid_thresh,
  input  logic [W-1:0]            out_thresh,
  output logic [N_IN-1:0]         hid_spike,
  output logic [N_IN*W-1:0]       hid_state,
  output logic                    spike_out,
  output logic [W-1:0]            state_out,
  output logic [CNT_W-1:0]        spike_count
);

  localparam int AW = addr_w(N_IN);
  localparam int SW = sum_w(N_IN, W_WT);
  localparam logic [AW:0] N_IN_L = (AW + 1)'(N_IN);

  logic [W_WT-1:0]  wt_reg [N_IN];
  logic [SW-1:0]    sum_r, sum_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     out_cur;
  logic             out_fire;
  logic [N_IN-1:0]  hid_fire_unused;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_hid
      lif_neuron_p #(.W(W), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT(REFRACT)) u_hid (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cur    (current[gi*W +: W]),
        .thresh (hid_thresh),
        .spike  (hid_spike[gi]),
        .fire   (hid_fire_unused[gi]),
        .state  (hid_state[gi*W +: W])
      );
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (hid_spike[i]) sum_next = sum_next + SW'(wt_reg[i]);
    end
  end

  // the sum can exceed the membrane range for wide weights, so clamp it
  assign out_cur = W'(sat_add(32'(sum_r), 32'd0, W));

  lif_neuron_p #(.W(W), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT(REFRACT)) u_out (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .cur    (out_cur),
    .thresh (out_thresh),
    .spike  (spike_out),
    .fire   (out_fire),
    .state  (state_out)
  );

  // weight writes bypass en; the sum on the write edge still sees old weights
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) wt_reg[i] <= W_WT'(1);
      sum_r   <= '0;
      cnt_reg <= '0;
    end else begin
      if (wt_we && ({1'b0, wt_addr} < N_IN_L)) wt_reg[wt_addr] <= wt_data;
      if (en) begin
        sum_r <= sum_next;
        if (out_fire && (cnt_reg != '1)) cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign spike_count = cnt_reg;

endmodule

// File: tb/tb_lif_layer_net.sv
// Self-checking bench for lif_layer_net: vector table plus a scoreboard of
// expectations scheduled a fixed number of edges after the stimulus.
module tb_lif_layer_net;

  localparam int N_IN = 8;
  localparam int W    = 8;
  localparam int N2   = 5;

  localparam int S_HSTATE0   = 0;
  localparam int S_HSPIKE    = 1;
  localparam int S_SUM       = 2;
  localparam int S_SPIKE_OUT = 3;
  localparam int S_STATE_OUT = 4;
  localparam int S_COUNT     = 5;
  localparam int S_HSPIKE2   = 6;
  localparam int S_SUM2      = 7;
  localparam int S_CNT2      = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, wt_we, spike_out;
  logic [N_IN*W-1:0] current, hid_state;
  logic [2:0]        wt_addr;
  logic [3:0]        wt_data;
  logic [W-1:0]      hid_thresh, out_thresh, state_out;
  logic [N_IN-1:0]   hid_spike;
  logic [15:0]       spike_count;

  logic            rst2, en2, wt_we2, spike_out2;
  logic [N2*W-1:0] current2, hid_state2;
  logic [2:0]      wt_addr2;
  logic [3:0]      wt_data2;
  logic [W-1:0]    hid_thresh2, out_thresh2, state_out2;
  logic [N2-1:0]   hid_spike2;
  logic [2:0]      spike_count2;

  lif_layer_net dut (
    .clk(clk), .rst(rst), .en(en), .current(current), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .hid_thresh(hid_thresh),
    .out_thresh(out_thresh), .hid_spike(hid_spike), .hid_state(hid_state),
    .spike_out(spike_out), .state_out(state_out), .spike_count(spike_count)
  );

  lif_layer_net #(.N_IN(N2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .current(current2), .wt_we(wt_we2),
    .wt_addr(wt_addr2), .wt_data(wt_data2), .hid_thresh(hid_thresh2),
    .out_thresh(out_thresh2), .hid_spike(hid_spike2), .hid_state(hid_state2),
    .spike_out(spike_out2), .state_out(state_out2), .spike_count(spike_count2)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    logic [7:0] cur;
    logic [7:0] st;
    logic       sp;
  } vec_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [63:0] get_sig(input int sel);
    case (sel)
      S_HSTATE0:   return 64'(hid_state[7:0]);
      S_HSPIKE:    return 64'(hid_spike);
      S_SUM:       return 64'(dut.sum_r);
      S_SPIKE_OUT: return 64'(spike_out);
      S_STATE_OUT: return 64'(state_out);
      S_COUNT:     return 64'(spike_count);
      S_HSPIKE2:   return 64'(hid_spike2);
      S_SUM2:      return 64'(dut2.sum_r);
      S_CNT2:      return 64'(spike_count2);
      default:     return '1;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic expect_at(input int d, input int sel, input logic [63:0] v, input string name);
    exp_t e;
    e.due  = cyc + d;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, get_sig(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b1;
    current = '0;
    wt_we   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t leak_tab [17];
    leak_tab = '{
      '{8'h40, 8'd64,  1'b0}, '{8'h40, 8'd112, 1'b0}, '{8'h40, 8'd148, 1'b0},
      '{8'h40, 8'd175, 1'b0}, '{8'h40, 8'd196, 1'b0}, '{8'h40, 8'd0,   1'b1},
      '{8'h40, 8'd0,   1'b0}, '{8'h40, 8'd0,   1'b0}, '{8'h40, 8'd64,  1'b0},
      '{8'h40, 8'd112, 1'b0}, '{8'h40, 8'd148, 1'b0}, '{8'h40, 8'd175, 1'b0},
      '{8'h40, 8'd196, 1'b0}, '{8'h40, 8'd0,   1'b1}, '{8'h40, 8'd0,   1'b0},
      '{8'h40, 8'd0,   1'b0}, '{8'h40, 8'd64,  1'b0}
    };

    rst = 1'b1; en = 1'b1; current = '1; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    hid_thresh = 8'h80; out_thresh = 8'h00;
    rst2 = 1'b1; en2 = 1'b1; current2 = '0; wt_we2 = 1'b0; wt_addr2 = '0; wt_data2 = '0;
    hid_thresh2 = 8'h80; out_thresh2 = 8'hFF;

    // reset with hot inputs: everything must stay cleared
    tick();
    tick();
    check("rst_hid_spike", 64'(hid_spike), 64'd0);
    check("rst_hid_state", hid_state, 64'd0);
    check("rst_spike_out", 64'(spike_out), 64'd0);
    check("rst_state_out", 64'(state_out), 64'd0);
    check("rst_spike_count", 64'(spike_count), 64'd0);
    check("rst_sum", 64'(dut.sum_r), 64'd0);
    rst = 1'b0; current = '0; current[7:0] = 8'hFF; out_thresh = 8'd200;
    expect_at(1, S_HSPIKE, 64'h01, "rel_hid_spike0");
    expect_at(2, S_SUM, 64'd1, "rel_unit_weight_sum");
    tick();
    current = '0;
    tick();
    tick();

    // leak / threshold / refractory table on channel 0
    do_reset();
    hid_thresh = 8'd200;
    for (int i = 0; i < 17; i++) begin
      current[7:0] = leak_tab[i].cur;
      expect_at(1, S_HSTATE0, 64'(leak_tab[i].st), $sformatf("leak_state[%0d]", i));
      expect_at(1, S_HSPIKE, 64'(leak_tab[i].sp), $sformatf("leak_spike[%0d]", i));
      tick();
    end

    // weighting and pipeline latency
    do_reset();
    wt_we = 1'b1; wt_addr = 3'd3; wt_data = 4'd15;
    tick();
    wt_we = 1'b0;
    hid_thresh = 8'h80; out_thresh = 8'd10; current = '0; current[3*8 +: 8] = 8'hFF;
    expect_at(1, S_HSPIKE, 64'h08, "wt_hid_spike3");
    expect_at(2, S_SUM, 64'd15, "wt_sum15");
    expect_at(2, S_SPIKE_OUT, 64'd0, "wt_no_early_spike");
    expect_at(3, S_SPIKE_OUT, 64'd1, "wt_spike_out");
    expect_at(3, S_COUNT, 64'd1, "wt_count1");
    expect_at(4, S_SPIKE_OUT, 64'd0, "wt_single_pulse");
    tick();
    current = '0;
    repeat (4) tick();

    // full weights, all channels firing; same-edge write uses old weight
    do_reset();
    wt_we = 1'b1; wt_data = 4'd15;
    for (int i = 0; i < N_IN; i++) begin
      wt_addr = 3'(i);
      tick();
    end
    wt_we = 1'b0;
    hid_thresh = 8'h80; out_thresh = 8'hFF; current = '1;
    expect_at(1, S_HSPIKE, 64'hFF, "sat_all_fire");
    expect_at(2, S_SUM, 64'd120, "sat_sum120");
    expect_at(3, S_STATE_OUT, 64'd120, "sat_out_state120");
    expect_at(4, S_SUM, 64'd0, "sat_sum_refr");
    expect_at(5, S_SUM, 64'd105, "sat_sum_new_wt0");
    tick();
    wt_we = 1'b1; wt_addr = 3'd0; wt_data = 4'd0;
    tick();
    wt_we = 1'b0;
    repeat (3) tick();

    // reset restores unit weights
    do_reset();
    hid_thresh = 8'h80; out_thresh = 8'hFF; current[2*8 +: 8] = 8'hFF;
    expect_at(1, S_HSPIKE, 64'h04, "rst_wt_hid_spike2");
    expect_at(2, S_SUM, 64'd1, "rst_wt_unit_sum");
    tick();
    current = '0;
    tick();

    // membrane saturation: 200 - 50 + 255 clamps to 255 and fires at thresh 255
    do_reset();
    hid_thresh = 8'hFF; out_thresh = 8'hFF; current[7:0] = 8'hC8;
    expect_at(1, S_HSTATE0, 64'd200, "sat_state200");
    tick();
    current[7:0] = 8'hFF;
    expect_at(1, S_HSPIKE, 64'h01, "sat_fire_no_wrap");
    expect_at(1, S_HSTATE0, 64'd0, "sat_state_cleared");
    tick();
    current = '0;

    // enable freeze while hidden neuron 0 is refractory, weight write accepted
    do_reset();
    hid_thresh = 8'd200; out_thresh = 8'd1; current[7:0] = 8'h40;
    expect_at(4, S_HSTATE0, 64'd175, "frz_pre_state");
    repeat (7) tick();
    en = 1'b0; wt_we = 1'b1; wt_addr = 3'd0; wt_data = 4'd5;
    for (int i = 0; i < 5; i++) begin
      expect_at(1, S_HSTATE0, 64'd0, $sformatf("frz_state[%0d]", i));
      expect_at(1, S_SUM, 64'd1, $sformatf("frz_sum[%0d]", i));
      expect_at(1, S_SPIKE_OUT, 64'd0, $sformatf("frz_spike_out[%0d]", i));
      expect_at(1, S_COUNT, 64'd0, $sformatf("frz_count[%0d]", i));
      tick();
      wt_we = 1'b0;
    end
    en = 1'b1;
    expect_at(1, S_SPIKE_OUT, 64'd1, "unfrz_spike_out");
    expect_at(1, S_COUNT, 64'd1, "unfrz_count1");
    expect_at(1, S_HSTATE0, 64'd0, "unfrz_refr_kept");
    expect_at(2, S_HSTATE0, 64'd64, "unfrz_state64");
    expect_at(8, S_SUM, 64'd5, "unfrz_wt_written");
    expect_at(9, S_SPIKE_OUT, 64'd1, "unfrz_spike_out2");
    expect_at(9, S_COUNT, 64'd2, "unfrz_count2");
    repeat (9) tick();
    current = '0;

    // second instance: out-of-range weight address is ignored
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    wt_we2 = 1'b1; wt_addr2 = 3'd7; wt_data2 = 4'd0; current2 = '1;
    expect_at(1, S_HSPIKE2, 64'h1F, "bad_addr_all_fire");
    expect_at(2, S_SUM2, 64'd5, "bad_addr_ignored");
    tick();
    wt_we2 = 1'b0; current2 = '0;
    tick();
    tick();

    // 3-bit counter with out_thresh 0 climbs to 7 and holds; reset clears it
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0; out_thresh2 = 8'h00;
    for (int n = 1; n <= 25; n++) begin
      expect_at(1, S_CNT2, 64'(((n + 2) / 3 > 7) ? 7 : (n + 2) / 3), $sformatf("cnt_sat[%0d]", n));
      tick();
    end
    rst2 = 1'b1;
    expect_at(1, S_CNT2, 64'd0, "cnt_mid_reset");
    tick();
    rst2 = 1'b0;
    expect_at(1, S_CNT2, 64'd1, "cnt_restart");
    tick();

    tick();
    foreach (sb[i]) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: never compared, expected %0h at cycle %0d", sb[i].name, sb[i].exp, sb[i].due);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
